// File: rtl/elevator_scheduler.sv
// SCAN elevator scheduler: latches one-hot floor calls, steps the car one floor per
// STEP_CYCLES, and holds the doors for DOOR_CYCLES at each served floor.
module elevator_scheduler #(
    parameter int NFLOORS     = 8,
    parameter int STEP_CYCLES = 4,
    parameter int DOOR_CYCLES = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NFLOORS-1:0] req,
    output logic [NFLOORS-1:0] cur_floor,
    output logic [NFLOORS-1:0] pending,
    output logic               dir_up,
    output logic               moving,
    output logic               door_open,
    output logic               arrive
);

    localparam int MAXC = (STEP_CYCLES > DOOR_CYCLES) ? STEP_CYCLES : DOOR_CYCLES;
    localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [TW-1:0]      STEP_LAST = TW'(STEP_CYCLES - 1);
    localparam logic [TW-1:0]      DOOR_LAST = TW'(DOOR_CYCLES - 1);
    localparam logic [NFLOORS-1:0] LSB       = NFLOORS'(1);

    typedef enum logic [1:0] {
        StIdle,
        StMove,
        StDoor
    } state_t;

    state_t             state_q, state_d;
    logic [NFLOORS-1:0] cur_q, cur_d;
    logic [NFLOORS-1:0] pend_q, pend_d;
    logic               dir_q, dir_d;
    logic               arrive_q, arrive_d;
    logic [TW-1:0]      timer_q, timer_d;

    logic [NFLOORS-1:0] pnext;
    logic [NFLOORS-1:0] above_mask, below_mask;
    logic [NFLOORS-1:0] next_floor;
    logic [NFLOORS-1:0] next_above_mask, next_below_mask;
    logic               here, above, below, ahead, behind, ahead_next;
    logic               step_done, door_done, req_here;

    // For a one-hot floor f: f-1 selects every floor below it, ~((f<<1)-1) every floor above.
    always_comb begin
        pnext           = pend_q | req;
        above_mask      = ~((cur_q << 1) - LSB);
        below_mask      = cur_q - LSB;
        here            = |(pnext & cur_q);
        above           = |(pnext & above_mask);
        below           = |(pnext & below_mask);
        ahead           = dir_q ? above : below;
        behind          = dir_q ? below : above;
        next_floor      = dir_q ? (cur_q << 1) : (cur_q >> 1);
        next_above_mask = ~((next_floor << 1) - LSB);
        next_below_mask = next_floor - LSB;
        ahead_next      = dir_q ? |(pnext & next_above_mask) : |(pnext & next_below_mask);
        step_done       = (timer_q == STEP_LAST);
        door_done       = (timer_q == DOOR_LAST);
        req_here        = |(req & cur_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cur_q    <= LSB;
            pend_q   <= '0;
            dir_q    <= 1'b1;
            arrive_q <= 1'b0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            pend_q   <= pend_d;
            dir_q    <= dir_d;
            arrive_q <= arrive_d;
            timer_q  <= timer_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        pend_d   = pnext;
        dir_d    = dir_q;
        timer_d  = timer_q;
        arrive_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                timer_d = '0;
                if (here) begin
                    state_d = StDoor;
                    pend_d  = pnext & ~cur_q;
                end else if (above && (dir_q || !below)) begin
                    dir_d   = 1'b1;
                    state_d = StMove;
                end else if (below) begin
                    dir_d   = 1'b0;
                    state_d = StMove;
                end
            end
            StMove: begin
                if (step_done) begin
                    timer_d = '0;
                    cur_d   = next_floor;
                    if (|(pnext & next_floor)) begin
                        state_d  = StDoor;
                        arrive_d = 1'b1;
                        pend_d   = pnext & ~next_floor;
                    end else if (!ahead_next) begin
                        state_d = StIdle;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StDoor: begin
                // A call at the open floor is absorbed and simply extends the dwell.
                pend_d = pnext & ~cur_q;
                if (req_here) begin
                    timer_d = '0;
                end else if (door_done) begin
                    timer_d = '0;
                    if (ahead) begin
                        state_d = StMove;
                    end else if (behind) begin
                        dir_d   = ~dir_q;
                        state_d = StMove;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cur_floor = cur_q;
        pending   = pend_q;
        dir_up    = dir_q;
        arrive    = arrive_q;
        moving    = (state_q == StMove);
        door_open = (state_q == StDoor);
    end

    a_no_edge_shift: assert property (@(posedge clk) disable iff (rst)
        (state_q == StMove && step_done) |-> (dir_q ? !cur_q[NFLOORS-1] : !cur_q[0]));

    a_floor_onehot: assert property (@(posedge clk) disable iff (rst) $onehot(cur_q));

    a_door_clear: assert property (@(posedge clk) disable iff (rst)
        (state_q == StDoor) |-> ((pend_q & cur_q) == '0));

endmodule

// File: tb/tb_elevator_scheduler.sv
// Bench for elevator_scheduler: directed scenarios plus random calls checked against an
// integer-floor reference model of the SCAN rules.
module tb_elevator_scheduler;

    localparam int NF = 8;
    localparam int SC = 4;
    localparam int DC = 3;

    localparam int MIdle = 0;
    localparam int MMove = 1;
    localparam int MDoor = 2;

    logic          clk;
    logic          rst;
    logic [NF-1:0] req;
    logic [NF-1:0] cur_floor;
    logic [NF-1:0] pending;
    logic          dir_up;
    logic          moving;
    logic          door_open;
    logic          arrive;

    int n_checks = 0;
    int n_fail   = 0;

    int            m_floor;
    bit            m_dir;
    logic [NF-1:0] m_pend;
    int            m_mode;
    int            m_elapsed;
    bit            m_arrive;

    elevator_scheduler #(
        .NFLOORS    (NF),
        .STEP_CYCLES(SC),
        .DOOR_CYCLES(DC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .cur_floor(cur_floor),
        .pending  (pending),
        .dir_up   (dir_up),
        .moving   (moving),
        .door_open(door_open),
        .arrive   (arrive)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input logic [NF-1:0] r);
        req = r;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        req = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic bit any_in(input logic [NF-1:0] p, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            if (i >= 0 && i < NF && p[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_floor   = 0;
        m_dir     = 1'b1;
        m_pend    = '0;
        m_mode    = MIdle;
        m_elapsed = 0;
        m_arrive  = 1'b0;
    endtask

    task automatic model_step(input logic [NF-1:0] r);
        logic [NF-1:0] p;
        bit up_any, dn_any;
        p        = m_pend | r;
        m_arrive = 1'b0;
        up_any   = any_in(p, m_floor + 1, NF - 1);
        dn_any   = any_in(p, 0, m_floor - 1);
        case (m_mode)
            MIdle: begin
                if (p[m_floor]) begin
                    m_mode = MDoor; p[m_floor] = 1'b0; m_elapsed = 0;
                end else if (up_any && (m_dir || !dn_any)) begin
                    m_dir = 1'b1; m_mode = MMove; m_elapsed = 0;
                end else if (dn_any) begin
                    m_dir = 1'b0; m_mode = MMove; m_elapsed = 0;
                end
            end
            MMove: begin
                m_elapsed++;
                if (m_elapsed == SC) begin
                    m_elapsed = 0;
                    m_floor += m_dir ? 1 : -1;
                    if (p[m_floor]) begin
                        m_mode = MDoor; m_arrive = 1'b1; p[m_floor] = 1'b0;
                    end else if (!(m_dir ? any_in(p, m_floor + 1, NF - 1)
                                         : any_in(p, 0, m_floor - 1))) begin
                        m_mode = MIdle;
                    end
                end
            end
            default: begin
                p[m_floor] = 1'b0;
                if (r[m_floor]) begin
                    m_elapsed = 0;
                end else begin
                    m_elapsed++;
                    if (m_elapsed == DC) begin
                        m_elapsed = 0;
                        if (m_dir ? up_any : dn_any) begin
                            m_mode = MMove;
                        end else if (m_dir ? dn_any : up_any) begin
                            m_dir = !m_dir; m_mode = MMove;
                        end else begin
                            m_mode = MIdle;
                        end
                    end
                end
            end
        endcase
        m_pend = p;
    endtask

    task automatic test_reset();
        req = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (cur_floor !== 8'h01 || pending !== 8'h00 || moving !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_held: cur=%h pend=%h mov=%b required 01 00 0",
                     cur_floor, pending, moving);
        end
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick('0);
            n_checks++;
            if ({cur_floor, pending, dir_up, moving, door_open, arrive} !== {8'h01, 8'h00, 4'b1000}) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d: cur=%h pend=%h dir/mov/door/arr=%b%b%b%b required 01 00 1000",
                         k, cur_floor, pending, dir_up, moving, door_open, arrive);
            end
        end
    endtask

    task automatic test_single_trip();
        logic [NF-1:0] exp_cur;
        apply_reset();
        tick(8'h08);
        n_checks++;
        if (moving !== 1'b1 || cur_floor !== 8'h01 || pending !== 8'h08) begin
            n_fail++;
            $display("FAIL trip_start: mov=%b cur=%h pend=%h required 1 01 08",
                     moving, cur_floor, pending);
        end
        for (int k = 1; k <= 16; k++) begin
            tick('0);
            exp_cur = (k >= 12) ? 8'h08 : (k >= 8) ? 8'h04 : (k >= 4) ? 8'h02 : 8'h01;
            n_checks++;
            if (cur_floor !== exp_cur || moving !== (k < 12) || door_open !== (k >= 12 && k < 15)
                || arrive !== (k == 12) || pending !== ((k < 12) ? 8'h08 : 8'h00)) begin
                n_fail++;
                $display("FAIL trip k=%0d: cur=%h mov=%b door=%b arr=%b pend=%h required cur=%h mov=%b door=%b arr=%b pend=%h",
                         k, cur_floor, moving, door_open, arrive, pending, exp_cur, (k < 12),
                         (k >= 12 && k < 15), (k == 12), ((k < 12) ? 8'h08 : 8'h00));
            end
        end
    endtask

    task automatic test_here();
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            tick((k == 0) ? 8'h01 : 8'h00);
            n_checks++;
            if (door_open !== (k < 3) || arrive !== 1'b0 || cur_floor !== 8'h01
                || pending !== 8'h00 || moving !== 1'b0) begin
                n_fail++;
                $display("FAIL here k=%0d: door=%b arr=%b cur=%h pend=%h mov=%b required door=%b arr=0 cur=01 pend=00 mov=0",
                         k, door_open, arrive, cur_floor, pending, moving, (k < 3));
            end
        end
    endtask

    task automatic test_scan();
        logic [NF-1:0] exp_stop [3];
        int stops;
        exp_stop[0] = 8'h10;
        exp_stop[1] = 8'h40;
        exp_stop[2] = 8'h02;
        stops = 0;
        apply_reset();
        tick(8'h40);
        repeat (8) tick('0);
        n_checks++;
        if (cur_floor !== 8'h04 || moving !== 1'b1 || dir_up !== 1'b1) begin
            n_fail++;
            $display("FAIL scan_setup: cur=%h mov=%b dir=%b required 04 1 1", cur_floor, moving, dir_up);
        end
        for (int c = 0; c < 200; c++) begin
            tick((c == 0) ? 8'h12 : 8'h00);
            if (arrive === 1'b1) begin
                if (stops < 3) begin
                    n_checks++;
                    if (cur_floor !== exp_stop[stops]) begin
                        n_fail++;
                        $display("FAIL scan_stop %0d: cur=%h required %h", stops, cur_floor, exp_stop[stops]);
                    end
                end
                if (stops == 2) begin
                    n_checks++;
                    if (dir_up !== 1'b0) begin
                        n_fail++;
                        $display("FAIL scan_dir: dir_up=%b required 0", dir_up);
                    end
                end
                stops++;
            end
            if (stops >= 3 && !moving && !door_open) break;
        end
        n_checks++;
        if (stops != 3 || pending !== 8'h00 || moving !== 1'b0 || door_open !== 1'b0) begin
            n_fail++;
            $display("FAIL scan_end: stops=%0d pend=%h mov=%b door=%b required 3 00 0 0",
                     stops, pending, moving, door_open);
        end
    endtask

    task automatic test_dwell();
        int  door_cycles;
        bit  saw_pend;
        apply_reset();
        tick(8'h08);
        repeat (12) tick('0);
        n_checks++;
        if (door_open !== 1'b1 || arrive !== 1'b1 || cur_floor !== 8'h08) begin
            n_fail++;
            $display("FAIL dwell_arrive: door=%b arr=%b cur=%h required 1 1 08", door_open, arrive, cur_floor);
        end
        door_cycles = 1;
        saw_pend    = 1'b0;
        for (int j = 0; j < 15; j++) begin
            tick((j < 5) ? 8'h08 : 8'h00);
            if (door_open === 1'b1) door_cycles++;
            if (pending[3] !== 1'b0) saw_pend = 1'b1;
        end
        n_checks++;
        if (door_cycles != 8) begin
            n_fail++;
            $display("FAIL dwell_len: door cycles=%0d required 8", door_cycles);
        end
        n_checks++;
        if (saw_pend) begin
            n_fail++;
            $display("FAIL dwell_latch: pending bit 3 set=%b required 0", saw_pend);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        tick(8'h10);
        repeat (10) tick('0);
        n_checks++;
        if (cur_floor !== 8'h04 || moving !== 1'b1 || pending !== 8'h10) begin
            n_fail++;
            $display("FAIL areset_pre: cur=%h mov=%b pend=%h required 04 1 10", cur_floor, moving, pending);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({cur_floor, pending, dir_up, moving, door_open, arrive} !== {8'h01, 8'h00, 4'b1000}) begin
            n_fail++;
            $display("FAIL areset_now: cur=%h pend=%h dir/mov/door/arr=%b%b%b%b required 01 00 1000",
                     cur_floor, pending, dir_up, moving, door_open, arrive);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [NF-1:0] r;
        int sel;
        apply_reset();
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                apply_reset();
                model_reset();
            end
            sel = $urandom_range(0, 15);
            if (sel == 0) r = NF'($urandom);
            else if (sel < 3) r = NF'(1) << $urandom_range(0, NF - 1);
            else r = '0;
            req = r;
            @(posedge clk);
            model_step(r);
            #1;
            n_checks++;
            if (cur_floor !== (NF'(1) << m_floor)) begin
                n_fail++;
                $display("FAIL rand_floor cyc %0d: cur=%h required %h", i, cur_floor, NF'(1) << m_floor);
            end
            n_checks++;
            if (pending !== m_pend) begin
                n_fail++;
                $display("FAIL rand_pending cyc %0d: pend=%h required %h", i, pending, m_pend);
            end
            n_checks++;
            if ({dir_up, moving, door_open, arrive} !==
                {m_dir, m_mode == MMove, m_mode == MDoor, m_arrive}) begin
                n_fail++;
                $display("FAIL rand_status cyc %0d: dir/mov/door/arr=%b%b%b%b required %b%b%b%b",
                         i, dir_up, moving, door_open, arrive,
                         m_dir, m_mode == MMove, m_mode == MDoor, m_arrive);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        test_reset();
        test_single_trip();
        test_here();
        test_scan();
        test_dwell();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/elevator_scheduler.md
# elevator_scheduler

Request scheduler and motion sequencer for the elevator car. It latches floor calls from a one-hot request bus into a pending set. It steps the car one floor at a time using a SCAN policy: keep going in the current direction while calls remain ahead, then reverse. At each served floor it holds the doors open for a fixed dwell. It sits between the floor-select decode logic (request source) and the floor display / motor drive (consumers of `cur_floor`, `moving`, `dir_up`).

## Interface

**Parameters**
- `NFLOORS`, default 8: number of floors; width of all floor vectors.
- `STEP_CYCLES`, default 4: clock cycles per one-floor move (≥1).
- `DOOR_CYCLES`, default 3: clock cycles the door stays open per stop (≥1).

**Ports** (clock and reset first)
- `clk` — input, 1: single clock; all state on rising edge.
- `rst` — input, 1: reset; asynchronous, active-high.
- `req` — input, NFLOORS: floor calls; any number of bits may be set; each set bit is sampled every cycle.
- `cur_floor` — output, NFLOORS: one-hot current floor; bit 0 is the lowest floor.
- `pending` — output, NFLOORS: latched, unserved calls.
- `dir_up` — output, 1: 1 = up, 0 = down; the SCAN preference direction.
- `moving` — output, 1: high in state MOVE.
- `door_open` — output, 1: high in state DOOR.
- `arrive` — output, 1: one-cycle pulse on the edge the car stops at a requested floor.

## Operation

- Reset values: `cur_floor` = 1 (floor 0), `pending` = 0, `dir_up` = 1, state IDLE, `moving` = `door_open` = `arrive` = 0, timer = 0.
- Merged request set: `pnext` = `pending` | `req`. All decisions below use `pnext`, so a request is acted on at the same edge that samples it.
- "Above" = any `pnext` bit strictly above `cur_floor`. "Below" = any bit strictly below. "Here" = the `pnext` bit at `cur_floor`.
- States: IDLE, MOVE, DOOR.
- **IDLE**
  - If Here: go to DOOR, clear the bit, timer = 0.
  - Else if Above and (`dir_up` or not Below): set `dir_up` = 1, go to MOVE.
  - Else if Below: set `dir_up` = 0, go to MOVE.
  - Else stay in IDLE.
- **MOVE**
  - Timer counts 0..STEP_CYCLES-1.
  - At terminal count, `cur_floor` shifts one position in `dir_up` direction and timer = 0.
  - If the new floor is in `pnext`: go to DOOR, pulse `arrive`, clear that bit.
  - Else if calls remain ahead in the current direction: stay in MOVE.
  - Else go to IDLE, which re-evaluates.
  - Calls at the floor just departed are latched into `pending` and served later.
- **DOOR**
  - Timer counts 0..DOOR_CYCLES-1.
  - A `req` at `cur_floor` while in DOOR is not latched; it restarts the timer at 0 (dwell extension).
  - At terminal count: if calls lie ahead, go to MOVE in the same direction. Else if calls lie behind, flip `dir_up` and go to MOVE. Else go to IDLE.
- Boundaries: `cur_floor` never shifts past bit 0 or bit NFLOORS-1. A MOVE toward an edge only occurs when a call lies beyond the current floor, so an out-of-range shift is unreachable. An assertion is required.
- `cur_floor` is always exactly one-hot. `pending` never holds the bit for `cur_floor` while in DOOR.
- Timer width is clog2(max(STEP_CYCLES, DOOR_CYCLES)) bits and must not wrap.

## Timing

- `req` sampled at edge E: visible in `pending` after E, unless it is consumed at E.
- From IDLE, state moves at E itself.
- MOVE entered at edge T: `cur_floor` changes at T+STEP_CYCLES. Each further floor adds STEP_CYCLES.
- DOOR entered at edge T: `door_open` is high for DOOR_CYCLES cycles. Exit happens at T+DOOR_CYCLES, plus any extensions.
- `arrive` is high exactly on the cycle following the stopping edge.
- IDLE-to-DOOR at Here does not pulse `arrive`.
- Async `rst` mid-MOVE or mid-DOOR forces all outputs to reset values immediately, without waiting for a clock edge. Calls in progress are lost.
- Reset release is synchronized externally. The first edge after deassert evaluates IDLE.

## Test plan

1. Apply reset, then release with `req` = 0 → `cur_floor` = 0x01, `pending` = 0x00, `dir_up` = 1, all status outputs 0 for 10 cycles.
2. From floor 0, pulse `req` = 0x08 for one cycle → `moving` = 1 immediately. `cur_floor` = 0x02 at +4, 0x04 at +8, 0x08 at +12 with `arrive` pulse. `door_open` for 3 cycles, then IDLE with `pending` = 0.
3. In IDLE at 0x01, pulse `req` = 0x01 → `door_open` for 3 cycles, no `arrive`, `cur_floor` unchanged.
4. Car at 0x04 moving up toward a pending 0x40; inject `req` = 0x12 → stops at 0x10 first, then 0x40. Then `dir_up` = 0 and the car returns to 0x02. `pending` = 0 at the end.
5. Hold `req` = 0x08 during DOOR at 0x08 for 5 cycles → `door_open` stays high 5+3 cycles total, and `pending` bit 3 never sets.
6. Assert `rst` asynchronously two cycles into MOVE from 0x04 → `cur_floor` = 0x01, `moving` = 0, `pending` = 0 before the next `clk` edge.
